if_stage: RTL and testbench

Instruction fetch stage with the IF/ID pipeline register. It holds the program counter and fetches 32-bit words from instruction memory over a req/ready handshake. Fetched words are presented to the decode stage as `instruction`, `if_pc` and `if_valid`. The block obeys the hazard unit's `stall`, `flush` and `pc_mode` outputs, and reports `fetch_busy` back to the hazard unit.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/if_id_reg.sv | 57 +++++
 rtl/if_stage.sv | 124 ++++++++++++
 tb/tb_if_stage.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage.
//   pc_mode_e     : hazard-unit PC source select (reserved encoding behaves as sequential)
//   fetch_state_e : fetch sequencer states
//   NOP_INSTR     : instruction word used for an IF/ID bubble
//   is_redirect() : true when pc_mode selects a branch or jump target
package cpu_pkg;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'b00,
      PC_BRANCH = 2'b01,
      PC_JUMP   = 2'b10,
      PC_RSVD   = 2'b11
   } pc_mode_e;

   typedef enum logic [1:0] {
      RUN0  = 2'b00,
      FETCH = 2'b01,
      DRAIN = 2'b10
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   function automatic logic is_redirect(input pc_mode_e mode);
      return (mode == PC_BRANCH) || (mode == PC_JUMP);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : load a bubble (highest priority)
//   stall               : hold current contents
//   buf_valid, buf_*    : skid-buffer entry, taken first when not stalled
//   mem_valid, mem_*    : word accepted from instruction memory this cycle
//   instruction, if_pc, if_valid : register contents presented to decode
module if_id_reg
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        stall,
   input  logic        buf_valid,
   input  logic [31:0] buf_instr,
   input  logic [31:0] buf_pc,
   input  logic        mem_valid,
   input  logic [31:0] mem_instr,
   input  logic [31:0] mem_pc,
   output logic [31:0] instruction,
   output logic [31:0] if_pc,
   output logic        if_valid
);

   // NOTE: state is written with non-blocking assignments so every register
   // samples pre-edge values regardless of evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instruction <= NOP_INSTR;
         if_pc       <= '0;
         if_valid    <= 1'b0;
      end else if (flush) begin
         instruction <= NOP_INSTR;
         if_pc       <= '0;
         if_valid    <= 1'b0;
      end else if (!stall) begin
         // A buffered word is older than anything memory returns, so it goes first.
         if (buf_valid) begin
            instruction <= buf_instr;
            if_pc       <= buf_pc;
            if_valid    <= 1'b1;
         end else if (mem_valid) begin
            instruction <= mem_instr;
            if_pc       <= mem_pc;
            if_valid    <= 1'b1;
         end else begin
            instruction <= NOP_INSTR;
            if_pc       <= '0;
            if_valid    <= 1'b0;
         end
      end
      // stall without flush: contents hold.
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, fetch sequencer, one-entry skid buffer and IF/ID register.
// Parameters:
//   RESET_PC : PC loaded at reset
//   PC_STEP  : byte increment for a sequential fetch
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   stall, flush, pc_mode       : hazard-unit controls
//   branch_target, jump_target  : redirect addresses for pc_mode 01 / 10
//   imem_req, imem_addr         : fetch request, held stable until imem_ready
//   imem_ready, imem_rdata      : memory accept and same-cycle read data
//   instruction, if_pc, if_valid: IF/ID outputs to decode
//   fetch_busy                  : fetch outstanding or discarded fetch draining
module if_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic [1:0]  pc_mode,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [31:0] if_pc,
   output logic        if_valid,
   output logic        fetch_busy
);

   fetch_state_e state;
   pc_mode_e     mode;
   logic [31:0]  pc;
   logic [31:0]  drain_addr;
   logic         buf_valid;
   logic [31:0]  buf_instr;
   logic [31:0]  buf_pc;
   logic         redirect;
   logic [31:0]  target;
   logic         handshake;
   logic         accept;
   logic         enter_drain;

   assign mode     = pc_mode_e'(pc_mode);
   assign redirect = is_redirect(mode);
   assign target   = (mode == PC_JUMP) ? jump_target : branch_target;

   // NOTE: every output of this block gets a default before the case so no
   // path leaves it unassigned (which would infer a latch).
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc;
      case (state)
         FETCH: imem_req = !buf_valid;
         DRAIN: begin
            // The abandoned request must stay on the bus until memory takes it.
            imem_req  = 1'b1;
            imem_addr = drain_addr;
         end
         default: ;
      endcase
   end

   assign handshake   = imem_req & imem_ready;
   // Only a FETCH-state handshake without a same-cycle redirect yields a usable word.
   assign accept      = handshake & (state == FETCH) & !redirect;
   assign enter_drain = (state == FETCH) & redirect & imem_req & !imem_ready;
   assign fetch_busy  = (state == DRAIN) | (imem_req & !imem_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RUN0;
         pc        <= RESET_PC;
         buf_valid <= 1'b0;
      end else begin
         case (state)
            RUN0:    state <= FETCH;
            FETCH:   if (enter_drain) state <= DRAIN;
            DRAIN:   if (imem_ready) state <= FETCH;
            default: state <= RUN0;
         endcase

         if (redirect)    pc <= target;
         else if (accept) pc <= pc + PC_STEP;

         // Redirect wins over both filling and draining the buffer.
         if (redirect)                          buf_valid <= 1'b0;
         else if (accept && stall)              buf_valid <= 1'b1;
         else if (buf_valid && !stall && !flush) buf_valid <= 1'b0;
      end
   end

   // NOTE: payload registers carry no reset; they are only read while the
   // matching valid/state bit says they were written.
   always_ff @(posedge clk) begin
      if (accept && stall) begin
         buf_instr <= imem_rdata;
         buf_pc    <= pc;
      end
      if (enter_drain) drain_addr <= pc;
   end

   if_id_reg u_if_id_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .stall       (stall),
      .buf_valid   (buf_valid),
      .buf_instr   (buf_instr),
      .buf_pc      (buf_pc),
      .mem_valid   (accept),
      .mem_instr   (imem_rdata),
      .mem_pc      (pc),
      .instruction (instruction),
      .if_pc       (if_pc),
      .if_valid    (if_valid)
   );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by randomized
// hazard/memory stimulus, compared against a behavioural model of the fetch rules.
module tb_if_stage;
   import cpu_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP  = 32'd4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush;
   logic [1:0]  pc_mode;
   logic [31:0] branch_target, jump_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instruction, if_pc;
   logic        if_valid, fetch_busy;

   if_stage #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .flush         (flush),
      .pc_mode       (pc_mode),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .instruction   (instruction),
      .if_pc         (if_pc),
      .if_valid      (if_valid),
      .fetch_busy    (fetch_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
   } ifid_t;

   bit          m_started;    // first post-reset cycle has passed
   bit          m_draining;   // an abandoned request is still on the bus
   logic [31:0] m_old_addr;
   logic [31:0] m_pc;
   ifid_t       m_buf[$];     // skid buffer, at most one entry
   ifid_t       m_id;         // expected IF/ID contents
   logic [31:0] mem_key;      // memory word = address ^ mem_key

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ mem_key;
   endfunction

   task automatic model_reset();
      m_started  = 1'b0;
      m_draining = 1'b0;
      m_old_addr = '0;
      m_pc       = RESET_PC;
      m_buf.delete();
      m_id       = '{NOP_INSTR, 32'h0, 1'b0};
   endtask

   // One clock cycle: called just after a falling edge, returns at the next one.
   task automatic step(input logic s, input logic f, input logic [1:0] m,
                       input logic [31:0] bt, input logic [31:0] jt, input logic rdy);
      logic        e_req, e_busy, hs, redir, good;
      logic [31:0] e_addr, tgt, rdata;
      e_req  = m_started && (m_draining || (m_buf.size() == 0));
      e_addr = m_draining ? m_old_addr : m_pc;
      e_busy = m_draining || (e_req && !rdy);
      rdata  = e_req ? word_at(e_addr) : $urandom;

      stall = s; flush = f; pc_mode = m;
      branch_target = bt; jump_target = jt;
      imem_ready = rdy; imem_rdata = rdata;
      #1;
      check("imem_req", 32'(imem_req), 32'(e_req));
      if (e_req) check("imem_addr", imem_addr, e_addr);
      check("fetch_busy", 32'(fetch_busy), 32'(e_busy));

      redir = (m == PC_BRANCH) || (m == PC_JUMP);
      tgt   = (m == PC_JUMP) ? jt : bt;
      hs    = e_req && rdy;
      good  = hs && !m_draining && !redir;

      if (f)                      m_id = '{NOP_INSTR, 32'h0, 1'b0};
      else if (!s) begin
         if (m_buf.size() > 0)    m_id = m_buf.pop_front();
         else if (good)           m_id = '{rdata, m_pc, 1'b1};
         else                     m_id = '{NOP_INSTR, 32'h0, 1'b0};
      end

      if (redir)            m_buf.delete();
      else if (good && s)   m_buf.push_back('{rdata, m_pc, 1'b1});

      if (!m_started) m_started = 1'b1;
      else if (m_draining) begin
         if (rdy) m_draining = 1'b0;
      end else if (redir && e_req && !rdy) begin
         m_draining = 1'b1;
         m_old_addr = m_pc;
      end

      if (redir)     m_pc = tgt;
      else if (good) m_pc = m_pc + PC_STEP;

      @(posedge clk); #1;
      check("instruction", instruction, m_id.instr);
      check("if_pc", if_pc, m_id.pc);
      check("if_valid", 32'(if_valid), 32'(m_id.valid));
      @(negedge clk);
   endtask

   // Called just after a falling edge; holds reset across one rising edge.
   task automatic apply_reset();
      rst_n = 1'b0;
      stall = 1'b0; flush = 1'b0; pc_mode = PC_SEQ;
      branch_target = '0; jump_target = '0; imem_ready = 1'b0; imem_rdata = '0;
      #1;
      check("rst_instruction", instruction, NOP_INSTR);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_valid", 32'(if_valid), 32'h0);
      check("rst_imem_req", 32'(imem_req), 32'h0);
      check("rst_fetch_busy", 32'(fetch_busy), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      rst_n = 1'b1;
      stall = 1'b0; flush = 1'b0; pc_mode = PC_SEQ;
      branch_target = '0; jump_target = '0; imem_ready = 1'b0; imem_rdata = '0;
      mem_key = 32'h0;   // words equal their addresses in the directed part
      model_reset();
      @(negedge clk);
      apply_reset();

      // Zero-wait streaming: nothing in cycle 1, first word at ID from cycle 3.
      for (int k = 1; k <= 6; k++) begin
         step(1'b0, 1'b0, PC_SEQ, '0, '0, 1'b1);
         if (k >= 2) begin
            check("stream_pc", if_pc, 32'(4 * (k - 2)));
            check("stream_valid", 32'(if_valid), 32'h1);
         end
      end

      // Three-cycle stall: word 20 is buffered while ID holds 16.
      step(1'b1, 1'b0, PC_SEQ, '0, '0, 1'b1);
      check("stall_hold_pc", if_pc, 32'd16);
      step(1'b1, 1'b0, PC_SEQ, '0, '0, 1'b1);
      step(1'b1, 1'b0, PC_SEQ, '0, '0, 1'b1);
      check("stall_hold_pc3", if_pc, 32'd16);
      step(1'b0, 1'b0, PC_SEQ, '0, '0, 1'b1);
      check("stall_release_pc", if_pc, 32'd20);
      step(1'b0, 1'b0, PC_SEQ, '0, '0, 1'b1);
      check("after_release_pc", if_pc, 32'd24);

      // Branch with flush at a handshake.
      step(1'b0, 1'b1, PC_BRANCH, 32'h100, '0, 1'b1);
      check("branch_bubble", 32'(if_valid), 32'h0);
      step(1'b0, 1'b0, PC_SEQ, '0, '0, 1'b1);
      check("branch_target_pc", if_pc, 32'h100);

      // Redirect while address 8 waits: drain it and discard the word.
      step(1'b0, 1'b1, PC_JUMP, '0, 32'h8, 1'b1);
      step(1'b0, 1'b1, PC_BRANCH, 32'h200, '0, 1'b0);
      check("drain_busy", 32'(fetch_busy), 32'h1);
      check("drain_addr", imem_addr, 32'h8);
      step(1'b0, 1'b0, PC_SEQ, '0, '0, 1'b0);
      step(1'b0, 1'b0, PC_SEQ, '0, '0, 1'b1);
      check("drain_discard", 32'(if_valid), 32'h0);
      check("post_drain_addr", imem_addr, 32'h200);
      step(1'b0, 1'b0, PC_SEQ, '0, '0, 1'b1);
      check("post_drain_pc", if_pc, 32'h200);

      // Stall and flush together while the buffer holds word 0x204.
      step(1'b1, 1'b0, PC_SEQ, '0, '0, 1'b1);
      step(1'b1, 1'b1, PC_SEQ, '0, '0, 1'b1);
      check("stall_flush_bubble", 32'(if_valid), 32'h0);
      step(1'b0, 1'b0, PC_SEQ, '0, '0, 1'b1);
      check("buffered_after_flush_pc", if_pc, 32'h204);
      check("buffered_after_flush_valid", 32'(if_valid), 32'h1);

      // Reset in the middle of a drain.
      step(1'b0, 1'b0, PC_BRANCH, 32'h300, '0, 1'b0);
      check("pre_reset_busy", 32'(fetch_busy), 32'h1);
      apply_reset();
      step(1'b0, 1'b0, PC_SEQ, '0, '0, 1'b1);
      step(1'b0, 1'b0, PC_SEQ, '0, '0, 1'b1);
      check("restart_pc", if_pc, RESET_PC);
      check("restart_valid", 32'(if_valid), 32'h1);

      // Randomized hazards, redirects and memory wait states.
      mem_key = $urandom;
      for (int i = 0; i < 3000; i++) begin
         logic       r_s, r_f, r_rdy;
         logic [1:0] r_m;
         r_s   = ($urandom_range(0, 4) == 0);
         r_f   = ($urandom_range(0, 7) == 0);
         r_rdy = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 9))
            0:       r_m = PC_BRANCH;
            1:       r_m = PC_JUMP;
            2:       r_m = PC_RSVD;
            default: r_m = PC_SEQ;
         endcase
         step(r_s, r_f, r_m, $urandom, $urandom, r_rdy);
         if ($urandom_range(0, 399) == 0) apply_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
